// File: rtl/grf_wb_if.sv
// ============================================================================
// Module      : grf_wb_if
// Description : Write-back / read-port bundle for the grf_wb register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface grf_wb_if;
    logic        WE;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] PC_W;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] wr_count;
    logic [31:0] last_pc;
    logic [4:0]  last_a3;
    logic [31:0] last_wd;

    // The master is the pipeline side: it drives the write-back request and read addresses.
    modport master (
        output WE, A1, A2, A3, WD, PC_W,
        input  RD1, RD2, wr_count, last_pc, last_a3, last_wd
    );

    modport slave (
        input  WE, A1, A2, A3, WD, PC_W,
        output RD1, RD2, wr_count, last_pc, last_a3, last_wd
    );
endinterface

`default_nettype wire

// File: rtl/grf_wb.sv
// ============================================================================
// Module      : grf_wb
// Description : 32x32-bit MIPS general register file, $0 hardwired to zero,
//               with write counter and last-write capture. Optional macro
//               GRF_BYPASS_EN adds same-cycle W->D write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grf_wb (
    input  wire logic  clk,
    input  wire logic  reset,
    grf_wb_if.slave    bus
);

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];
    logic [31:0] wr_count_q, wr_count_d;
    logic [31:0] last_pc_q,  last_pc_d;
    logic [4:0]  last_a3_q,  last_a3_d;
    logic [31:0] last_wd_q,  last_wd_d;
    logic        wr_en;

    assign wr_en = bus.WE && (bus.A3 != 5'd0);

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        wr_count_d = wr_count_q;
        last_pc_d  = last_pc_q;
        last_a3_d  = last_a3_q;
        last_wd_d  = last_wd_q;
        if (wr_en) begin
            regs_d[bus.A3] = bus.WD;
            wr_count_d     = wr_count_q + 32'd1;
            last_pc_d      = bus.PC_W;
            last_a3_d      = bus.A3;
            last_wd_d      = bus.WD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            wr_count_q <= 32'd0;
            last_pc_q  <= 32'd0;
            last_a3_q  <= 5'd0;
            last_wd_q  <= 32'd0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_count_q <= wr_count_d;
            last_pc_q  <= last_pc_d;
            last_a3_q  <= last_a3_d;
            last_wd_q  <= last_wd_d;
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] val;
        val = 32'd0;
        if (addr != 5'd0) begin
`ifdef GRF_BYPASS_EN
            // Forward the in-flight write so decode never sees a stale operand.
            if (wr_en && (addr == bus.A3)) begin
                val = bus.WD;
            end else begin
                val = regs_q[addr];
            end
`else
            val = regs_q[addr];
`endif
        end
        return val;
    endfunction

    assign bus.RD1      = read_port(bus.A1);
    assign bus.RD2      = read_port(bus.A2);
    assign bus.wr_count = wr_count_q;
    assign bus.last_pc  = last_pc_q;
    assign bus.last_a3  = last_a3_q;
    assign bus.last_wd  = last_wd_q;

endmodule

`default_nettype wire
